// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared state encoding for the sequential code lock
package lock_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ENTRY   = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } lock_state_t;

endpackage

// File: rtl/btn_press_det.sv
// rtl/btn_press_det.sv - button rising-edge detect, one-hot check and digit encode
module btn_press_det #(
    parameter int NUM_BTN = 3,
    parameter int DIG_W   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn,
    output logic               press,
    output logic               valid,
    output logic [DIG_W-1:0]   digit
);

    logic [NUM_BTN-1:0] btn_q;
    logic [NUM_BTN-1:0] rising;

    // btn_q tracks btn unconditionally so a button held across a state change never reads as a press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn;
        end
    end

    assign rising = btn & ~btn_q;
    assign press  = |rising;
    assign valid  = press && ((rising & (rising - NUM_BTN'(1))) == '0);

    always_comb begin
        digit = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (rising[i]) begin
                digit = DIG_W'(i);
            end
        end
    end

endmodule

// File: rtl/seq_code_lock.sv
// rtl/seq_code_lock.sv - sequential combination lock with open window, idle timeout and lockout
module seq_code_lock
    import lock_pkg::*;
#(
    parameter int                          NUM_BTN     = 3,
    parameter int                          CODE_LEN    = 4,
    parameter int                          DIG_W       = 2,
    parameter logic [CODE_LEN*DIG_W-1:0]   RST_CODE    = 8'b00_01_00_10,
    parameter int                          OPEN_CYC    = 50_000_000,
    parameter int                          TIMEOUT_CYC = 250_000_000,
    parameter int                          MAX_FAIL    = 3,
    parameter int                          LOCK_CYC    = 500_000_000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_BTN-1:0]              btn,
    input  logic                            code_wr,
    input  logic [CODE_LEN*DIG_W-1:0]       code_wdata,
    output logic                            open,
    output logic                            fail,
    output logic                            locked_out,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
    output logic [$clog2(CODE_LEN+1)-1:0]   pos
);

    localparam int FC_W  = $clog2(MAX_FAIL+1);
    localparam int POS_W = $clog2(CODE_LEN+1);
    localparam int MAX_CYC = (OPEN_CYC > TIMEOUT_CYC)
                           ? ((OPEN_CYC > LOCK_CYC) ? OPEN_CYC : LOCK_CYC)
                           : ((TIMEOUT_CYC > LOCK_CYC) ? TIMEOUT_CYC : LOCK_CYC);
    localparam int TMR_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // The shared timer is loaded with N-1 and the state acts on the cycle it reads zero
    localparam logic [TMR_W-1:0] OPEN_LOAD    = TMR_W'(OPEN_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] LOCK_LOAD    = TMR_W'(LOCK_CYC - 1);
    localparam logic [POS_W-1:0] LAST_POS     = POS_W'(CODE_LEN - 1);
    localparam logic [FC_W-1:0]  FAIL_MAX     = FC_W'(MAX_FAIL);

    lock_state_t                 state, state_n;
    logic [TMR_W-1:0]            timer, timer_n;
    logic [POS_W-1:0]            pos_q, pos_n;
    logic                        err, err_n;
    logic [CODE_LEN*DIG_W-1:0]   code, code_n;
    logic [FC_W-1:0]             fail_cnt_q, fail_cnt_n, fail_cnt_inc;
    logic                        fail_q, fail_n;

    logic                        press;
    logic                        valid;
    logic [DIG_W-1:0]            digit;
    logic [DIG_W-1:0]            exp_digit;
    logic                        mismatch;

    btn_press_det #(
        .NUM_BTN (NUM_BTN),
        .DIG_W   (DIG_W)
    ) u_press_det (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .press (press),
        .valid (valid),
        .digit (digit)
    );

    always_comb begin
        exp_digit = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (pos_q == POS_W'(i)) begin
                exp_digit = code[i*DIG_W +: DIG_W];
            end
        end
    end

    assign mismatch     = !valid || (digit != exp_digit);
    assign fail_cnt_inc = (fail_cnt_q == FAIL_MAX) ? fail_cnt_q : fail_cnt_q + FC_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ENTRY;
            timer      <= '0;
            pos_q      <= '0;
            err        <= 1'b0;
            code       <= RST_CODE;
            fail_cnt_q <= '0;
            fail_q     <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            pos_q      <= pos_n;
            err        <= err_n;
            code       <= code_n;
            fail_cnt_q <= fail_cnt_n;
            fail_q     <= fail_n;
        end
    end

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        pos_n      = pos_q;
        err_n      = err;
        code_n     = code;
        fail_cnt_n = fail_cnt_q;
        fail_n     = 1'b0;

        case (state)
            ENTRY: begin
                if (press) begin
                    if (pos_q == LAST_POS) begin
                        pos_n = '0;
                        err_n = 1'b0;
                        if (err || mismatch) begin
                            fail_n     = 1'b1;
                            fail_cnt_n = fail_cnt_inc;
                            if (fail_cnt_inc == FAIL_MAX) begin
                                state_n = LOCKOUT;
                                timer_n = LOCK_LOAD;
                            end
                        end else begin
                            state_n    = OPEN;
                            timer_n    = OPEN_LOAD;
                            fail_cnt_n = '0;
                        end
                    end else begin
                        pos_n   = pos_q + POS_W'(1);
                        err_n   = err || mismatch;
                        timer_n = TIMEOUT_LOAD;
                    end
                end else if (pos_q != '0) begin
                    // Idle abort is silent: no fail pulse and the failure count is kept
                    if (timer == '0) begin
                        pos_n = '0;
                        err_n = 1'b0;
                    end else begin
                        timer_n = timer - TMR_W'(1);
                    end
                end
            end

            OPEN: begin
                if (code_wr) begin
                    code_n = code_wdata;
                end
                if (timer == '0) begin
                    state_n = ENTRY;
                    pos_n   = '0;
                    err_n   = 1'b0;
                end else begin
                    timer_n = timer - TMR_W'(1);
                end
            end

            LOCKOUT: begin
                if (timer == '0) begin
                    state_n    = ENTRY;
                    pos_n      = '0;
                    err_n      = 1'b0;
                    fail_cnt_n = '0;
                end else begin
                    timer_n = timer - TMR_W'(1);
                end
            end

            default: begin
                state_n = ENTRY;
                pos_n   = '0;
                err_n   = 1'b0;
            end
        endcase
    end

    assign open       = (state == OPEN);
    assign locked_out = (state == LOCKOUT);
    assign fail       = fail_q;
    assign fail_cnt   = fail_cnt_q;
    assign pos        = pos_q;

endmodule

// File: tb/tb_seq_code_lock.sv
// tb/tb_seq_code_lock.sv - directed self-checking bench for seq_code_lock
module tb_seq_code_lock;

    localparam logic [2:0] B0 = 3'b001;
    localparam logic [2:0] B1 = 3'b010;
    localparam logic [2:0] B2 = 3'b100;
    localparam logic [7:0] CODE_RST  = 8'b00_01_00_10;
    localparam logic [7:0] CODE_0011 = 8'b01_01_00_00;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] btn = '0;
    logic       code_wr = 1'b0;
    logic [7:0] code_wdata = '0;
    logic       open;
    logic       fail;
    logic       locked_out;
    logic [1:0] fail_cnt;
    logic [2:0] pos;

    int errors = 0;
    int checks = 0;
    int fail_pulses = 0;
    int open_cycles = 0;
    int locked_cycles = 0;

    seq_code_lock #(
        .NUM_BTN     (3),
        .CODE_LEN    (4),
        .DIG_W       (2),
        .RST_CODE    (CODE_RST),
        .OPEN_CYC    (8),
        .TIMEOUT_CYC (20),
        .MAX_FAIL    (3),
        .LOCK_CYC    (30)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .code_wr    (code_wr),
        .code_wdata (code_wdata),
        .open       (open),
        .fail       (fail),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt),
        .pos        (pos)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fail)       fail_pulses++;
        if (open)       open_cycles++;
        if (locked_out) locked_cycles++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_hold(input logic [2:0] b);
        btn = b;
        step();
        btn = '0;
    endtask

    task automatic press(input logic [2:0] b);
        press_hold(b);
        step();
    endtask

    task automatic enter_seq(input logic [2:0] b0, input logic [2:0] b1,
                             input logic [2:0] b2, input logic [2:0] b3);
        press(b0);
        press(b1);
        press(b2);
        press_hold(b3);
    endtask

    task automatic do_reset();
        btn = '0;
        code_wr = 1'b0;
        code_wdata = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic wait_open_low();
        for (int i = 0; i < 100 && open; i++) step();
        checks++;
        if (open !== 1'b0) begin errors++; $display("FAIL open_window_end: got %0b want 0", open); end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (open !== 1'b0)       begin errors++; $display("FAIL reset_open: got %0b want 0", open); end
        checks++; if (fail !== 1'b0)       begin errors++; $display("FAIL reset_fail: got %0b want 0", fail); end
        checks++; if (locked_out !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", locked_out); end
        checks++; if (fail_cnt !== 2'd0)   begin errors++; $display("FAIL reset_fail_cnt: got %0d want 0", fail_cnt); end
        checks++; if (pos !== 3'd0)        begin errors++; $display("FAIL reset_pos: got %0d want 0", pos); end
    endtask

    task automatic test_open_correct();
        int f0, o0;
        do_reset();
        f0 = fail_pulses;
        o0 = open_cycles;
        enter_seq(B2, B0, B1, B0);
        checks++; if (open !== 1'b1) begin errors++; $display("FAIL open_latency: got %0b want 1", open); end
        step();
        wait_open_low();
        checks++; if (open_cycles - o0 !== 8) begin errors++; $display("FAIL open_length: got %0d want 8", open_cycles - o0); end
        checks++; if (fail_pulses - f0 !== 0) begin errors++; $display("FAIL open_no_fail: got %0d want 0", fail_pulses - f0); end
    endtask

    task automatic test_wrong_seq();
        int f0;
        do_reset();
        f0 = fail_pulses;
        press(B2);
        press(B1);
        checks++; if (pos !== 3'd2)           begin errors++; $display("FAIL wrong_pos_mid: got %0d want 2", pos); end
        checks++; if (fail_pulses - f0 !== 0) begin errors++; $display("FAIL wrong_early_fail: got %0d want 0", fail_pulses - f0); end
        press(B1);
        press_hold(B0);
        checks++; if (fail !== 1'b1)     begin errors++; $display("FAIL wrong_fail_pulse: got %0b want 1", fail); end
        checks++; if (fail_cnt !== 2'd1) begin errors++; $display("FAIL wrong_fail_cnt: got %0d want 1", fail_cnt); end
        checks++; if (pos !== 3'd0)      begin errors++; $display("FAIL wrong_pos_end: got %0d want 0", pos); end
        step();
        checks++; if (fail !== 1'b0)          begin errors++; $display("FAIL wrong_fail_width: got %0b want 0", fail); end
        checks++; if (fail_pulses - f0 !== 1) begin errors++; $display("FAIL wrong_fail_count: got %0d want 1", fail_pulses - f0); end
    endtask

    task automatic test_lockout();
        int l0, o0;
        do_reset();
        l0 = locked_cycles;
        o0 = open_cycles;
        for (int n = 0; n < 2; n++) begin
            enter_seq(B2, B1, B1, B0);
            step();
        end
        checks++; if (locked_out !== 1'b0) begin errors++; $display("FAIL lock_early: got %0b want 0", locked_out); end
        enter_seq(B2, B1, B1, B0);
        checks++; if (locked_out !== 1'b1) begin errors++; $display("FAIL lock_enter: got %0b want 1", locked_out); end
        checks++; if (fail_cnt !== 2'd3)   begin errors++; $display("FAIL lock_fail_cnt: got %0d want 3", fail_cnt); end
        step();
        enter_seq(B2, B0, B1, B0);
        checks++; if (open !== 1'b0) begin errors++; $display("FAIL lock_ignores_code: got %0b want 0", open); end
        checks++; if (pos !== 3'd0)  begin errors++; $display("FAIL lock_pos: got %0d want 0", pos); end
        step();
        for (int i = 0; i < 100 && locked_out; i++) step();
        checks++; if (locked_out !== 1'b0)          begin errors++; $display("FAIL lock_exit: got %0b want 0", locked_out); end
        checks++; if (locked_cycles - l0 !== 30)    begin errors++; $display("FAIL lock_length: got %0d want 30", locked_cycles - l0); end
        checks++; if (fail_cnt !== 2'd0)            begin errors++; $display("FAIL lock_exit_fail_cnt: got %0d want 0", fail_cnt); end
        checks++; if (open_cycles - o0 !== 0)       begin errors++; $display("FAIL lock_no_open: got %0d want 0", open_cycles - o0); end
    endtask

    task automatic test_timeout();
        int f0;
        do_reset();
        f0 = fail_pulses;
        press(B2);
        for (int i = 0; i < 18; i++) step();
        checks++; if (pos !== 3'd1) begin errors++; $display("FAIL timeout_before: got %0d want 1", pos); end
        step();
        checks++; if (pos !== 3'd0)           begin errors++; $display("FAIL timeout_pos: got %0d want 0", pos); end
        checks++; if (fail_pulses - f0 !== 0) begin errors++; $display("FAIL timeout_no_fail: got %0d want 0", fail_pulses - f0); end
        checks++; if (fail_cnt !== 2'd0)      begin errors++; $display("FAIL timeout_fail_cnt: got %0d want 0", fail_cnt); end
        enter_seq(B2, B0, B1, B0);
        checks++; if (open !== 1'b1) begin errors++; $display("FAIL timeout_then_open: got %0b want 1", open); end
        step();
        wait_open_low();
    endtask

    task automatic test_code_write();
        do_reset();
        enter_seq(B2, B0, B1, B0);
        step();
        code_wr = 1'b1;
        code_wdata = CODE_0011;
        step();
        code_wr = 1'b0;
        wait_open_low();
        enter_seq(B2, B0, B1, B0);
        checks++; if (fail !== 1'b1) begin errors++; $display("FAIL code_old_rejected: got %0b want 1", fail); end
        checks++; if (open !== 1'b0) begin errors++; $display("FAIL code_old_not_open: got %0b want 0", open); end
        step();
        enter_seq(B0, B0, B1, B1);
        checks++; if (open !== 1'b1)     begin errors++; $display("FAIL code_new_open: got %0b want 1", open); end
        checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL code_new_fail_cnt: got %0d want 0", fail_cnt); end
        for (int i = 0; i < 7; i++) step();
        checks++; if (open !== 1'b1) begin errors++; $display("FAIL code_last_open_cycle: got %0b want 1", open); end
        code_wr = 1'b1;
        code_wdata = CODE_RST;
        step();
        code_wr = 1'b0;
        checks++; if (open !== 1'b0) begin errors++; $display("FAIL code_expiry: got %0b want 0", open); end
        code_wr = 1'b1;
        code_wdata = CODE_0011;
        step();
        code_wr = 1'b0;
        enter_seq(B2, B0, B1, B0);
        checks++; if (open !== 1'b1) begin errors++; $display("FAIL code_expiry_write_kept: got %0b want 1", open); end
        step();
        wait_open_low();
    endtask

    task automatic test_invalid_and_reset();
        int f0;
        do_reset();
        f0 = fail_pulses;
        press(3'b101);
        press(B0);
        press(B1);
        checks++; if (pos !== 3'd3)           begin errors++; $display("FAIL multi_pos: got %0d want 3", pos); end
        checks++; if (fail_pulses - f0 !== 0) begin errors++; $display("FAIL multi_early_fail: got %0d want 0", fail_pulses - f0); end
        press_hold(B0);
        checks++; if (fail !== 1'b1)     begin errors++; $display("FAIL multi_fail: got %0b want 1", fail); end
        checks++; if (fail_cnt !== 2'd1) begin errors++; $display("FAIL multi_fail_cnt: got %0d want 1", fail_cnt); end
        step();
        press(B2);
        press(B0);
        checks++; if (pos !== 3'd2) begin errors++; $display("FAIL mid_entry_pos: got %0d want 2", pos); end
        reset = 1'b1;
        #2;
        checks++; if (pos !== 3'd0)      begin errors++; $display("FAIL mid_entry_reset_pos: got %0d want 0", pos); end
        checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL mid_entry_reset_fail_cnt: got %0d want 0", fail_cnt); end
        step();
        reset = 1'b0;
        step();
        enter_seq(B2, B0, B1, B0);
        step();
        code_wr = 1'b1;
        code_wdata = CODE_0011;
        step();
        code_wr = 1'b0;
        wait_open_low();
        for (int n = 0; n < 3; n++) begin
            enter_seq(B2, B1, B1, B0);
            step();
        end
        checks++; if (locked_out !== 1'b1) begin errors++; $display("FAIL lock_before_reset: got %0b want 1", locked_out); end
        reset = 1'b1;
        #2;
        checks++; if (locked_out !== 1'b0) begin errors++; $display("FAIL lock_reset_locked: got %0b want 0", locked_out); end
        checks++; if (fail_cnt !== 2'd0)   begin errors++; $display("FAIL lock_reset_fail_cnt: got %0d want 0", fail_cnt); end
        checks++; if ({open, fail} !== 2'b00) begin errors++; $display("FAIL lock_reset_open_fail: got %b want 00", {open, fail}); end
        step();
        reset = 1'b0;
        step();
        enter_seq(B2, B0, B1, B0);
        checks++; if (open !== 1'b1) begin errors++; $display("FAIL reset_restores_code: got %0b want 1", open); end
        step();
        wait_open_low();
    endtask

    initial begin
        test_reset();
        test_open_correct();
        test_wrong_seq();
        test_lockout();
        test_timeout();
        test_code_write();
        test_invalid_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
